unary_frame_counter: RTL and testbench
======================================

// Module: unary_frame_counter
// PURPOSE
//  Downstream consumer of the unary number generator (UNG) bit-stream.
//  - Counts the 1s in un_data over one frame of 2**width clock cycles.
//  - Presents the total as a binary word on a valid/ready output; this is the
//    unary-to-binary back-conversion after stochastic/unary arithmetic.
//  - Optional continuous mode tracks back-to-back UNG frames without gaps.
// PARAMETERS
//  width       4  data precision m; frame length FRAME = 2**width cycles
//  CONTINUOUS  0  0: one frame per start pulse; 1: frames repeat back-to-back until rst
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        reset, synchronous, active-high
//  start        in   1        begin frame collection (sampled in IDLE only)
//  un_data      in   1        unary bit-stream from UNG
//  count_out    out  width+1  ones counted in last completed frame, 0..2**width
//  count_valid  out  1        count_out holds an unconsumed result
//  count_ready  in   1        consumer accepts count_out when high with count_valid
//  busy         out  1        high while in COLLECT
//  overrun      out  1        sticky: a result was overwritten before it was accepted
// BEHAVIOUR
//  Reset values (rst high at a clock edge):
//   - state=IDLE; count_out, count_valid, busy, overrun, internal acc and cnt all 0.
//   - rst mid-frame aborts the frame; partial count discarded; no count_valid.
//  States: IDLE, COLLECT, DONE (DONE is unused when CONTINUOUS=1).
//  IDLE:
//   - start=1 -> COLLECT next cycle with acc=0, cnt=0.
//   - start=0 -> stay in IDLE.
//  COLLECT (busy=1):
//   - Each cycle: acc += un_data; cnt += 1.
//   - cnt is width bits and wraps; acc is width+1 bits and never overflows.
//   - Last sample is on the cycle with cnt == 2**width-1. On that edge:
//     count_out <= acc + un_data; count_valid <= 1.
//   - CONTINUOUS=0: go to DONE.
//   - CONTINUOUS=1: stay in COLLECT with acc=0 and cnt wrapping to 0, so no
//     sample cycle is lost.
//  DONE (CONTINUOUS=0):
//   - Hold count_out until count_valid && count_ready, then clear count_valid
//     and go to IDLE.
//   - start is ignored in DONE and COLLECT (no queueing).
//  Latency:
//   - start high at edge T -> un_data sampled at edges T+1 .. T+2**width.
//   - count_valid rises after edge T+2**width.
//  Handshake:
//   - Transfer occurs on an edge with count_valid && count_ready.
//   - count_out is stable while count_valid=1 and no transfer has occurred.
//   - count_ready while count_valid=0 has no effect.
//  Simultaneous events (CONTINUOUS=1 only):
//   - New result and transfer on the same edge: load new result; count_valid
//     stays 1; no overrun.
//   - New result while count_valid=1 with no transfer: overwrite count_out;
//     set overrun=1. overrun clears only on rst.
//  UNG alignment:
//   - UNG output for value b holds b+1 ones per frame, so expect count_out = b+1.
//   - Upstream asserts start in the cycle before UNG's first registered un_data.
// TESTING (width=4, FRAME=16)
//  1. un_data=1 for all 16 sample cycles after start -> count_out=16, count_valid
//     at T+17, busy high exactly 16 cycles.
//  2. un_data=0 throughout -> count_out=0, count_valid=1; count_ready=1 for one
//     cycle -> count_valid=0, state IDLE.
//  3. Driven by UNG with binary_data_in=5, aligned start -> count_out=6; repeat
//     for b=0 (->1) and b=15 (->16).
//  4. count_ready held low 40 cycles after result -> count_out and count_valid
//     stable; extra start pulses ignored; then ready -> single transfer.
//  5. CONTINUOUS=1, frames with 3, 7, 9 ones, ready held low -> count_out=9,
//     overrun=1. Rerun with ready=1 on each completion edge -> overrun stays 0.
//  6. rst asserted at sample 8 of a frame -> next cycle all outputs 0, IDLE.
//     New start then yields a correct full-frame count.

Source files
------------

// File: rtl/unary_frame_counter_if.sv
// Result channel of the unary frame counter: binary count with valid/ready handshake.
interface unary_frame_counter_if #(
    parameter int unsigned width = 4
) ();
    logic [width:0] count_out;
    logic           count_valid;
    logic           count_ready;

    modport master (
        output count_out,
        output count_valid,
        input  count_ready
    );

    modport slave (
        input  count_out,
        input  count_valid,
        output count_ready
    );
endinterface

// File: rtl/unary_frame_counter.sv
// Counts ones of a unary bit-stream over 2**width cycles and presents the total
// as a binary word on a valid/ready channel; optional gapless continuous mode.
module unary_frame_counter #(
    parameter int unsigned width      = 4,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  un_data,
    unary_frame_counter_if.master res,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [width:0]   acc_q, acc_d;
    logic [width-1:0] cnt_q, cnt_d;
    logic [width:0]   out_q, out_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [width:0]   un_ext;
    logic             xfer;

    assign un_ext = {{width{1'b0}}, un_data};
    assign xfer   = valid_q && res.count_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (xfer) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCollect;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StCollect: begin
                acc_d = acc_q + un_ext;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {width{1'b1}}) begin
                    out_d   = acc_q + un_ext;
                    valid_d = 1'b1;
                    acc_d   = '0;
                    // Unaccepted result being replaced is only possible in continuous mode.
                    if (valid_q && !xfer) begin
                        ovr_d = 1'b1;
                    end
                    if (!CONTINUOUS) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign res.count_out   = out_q;
    assign res.count_valid = valid_q;
    assign busy            = (state_q == StCollect);
    assign overrun         = ovr_q;

endmodule

// File: tb/tb_unary_frame_counter.sv
// Scoreboarded bench: single-shot (dut0) and continuous (dut1) counters, width=4.
module tb_unary_frame_counter;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic start0, un0, busy0, ovr0;
    logic start1, un1, busy1, ovr1;

    unary_frame_counter_if #(.width(W)) if0 ();
    unary_frame_counter_if #(.width(W)) if1 ();

    unary_frame_counter #(.width(W), .CONTINUOUS(1'b0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .start   (start0),
        .un_data (un0),
        .res     (if0),
        .busy    (busy0),
        .overrun (ovr0)
    );

    unary_frame_counter #(.width(W), .CONTINUOUS(1'b1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .un_data (un1),
        .res     (if1),
        .busy    (busy1),
        .overrun (ovr1)
    );

    int vectors     = 0;
    int miscompares = 0;
    int q0[$];
    int q1[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: a transfer is pending when valid && ready are seen mid-cycle.
    always @(negedge clk) begin
        if (!rst && if0.count_valid && if0.count_ready) begin
            if (q0.size() == 0) check("dut0 unexpected transfer", int'(if0.count_out), -1);
            else check("dut0 transfer", int'(if0.count_out), q0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.count_valid && if1.count_ready) begin
            if (q1.size() == 0) check("dut1 unexpected transfer", int'(if1.count_out), -1);
            else check("dut1 transfer", int'(if1.count_out), q1.pop_front());
        end
    end

    task automatic frame0(input logic [15:0] pat, input string tag);
        int busy_cycles = 0;
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            un0 = pat[i];
            if (busy0) busy_cycles++;
            if (i == 15) check({tag, " valid before last edge"}, int'(if0.count_valid), 0);
            @(posedge clk); #1;
        end
        un0 = 1'b0;
        check({tag, " busy cycles"}, busy_cycles, 16);
        check({tag, " busy after frame"}, int'(busy0), 0);
        check({tag, " valid after frame"}, int'(if0.count_valid), 1);
    endtask

    task automatic accept0(input string tag);
        if0.count_ready = 1'b1;
        @(posedge clk); #1 if0.count_ready = 1'b0;
        check({tag, " valid after accept"}, int'(if0.count_valid), 0);
        check({tag, " busy after accept"}, int'(busy0), 0);
    endtask

    task automatic start1_pulse();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic feed1(input logic [15:0] pat, input bit rdy_last);
        for (int i = 0; i < 16; i++) begin
            un1 = pat[i];
            if1.count_ready = rdy_last && (i == 15);
            @(posedge clk); #1;
        end
        if1.count_ready = 1'b0;
        un1 = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; un0 = 1'b0; if0.count_ready = 1'b0;
        start1 = 1'b0; un1 = 1'b0; if1.count_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset dut0 count_out", int'(if0.count_out), 0);
        check("reset dut0 valid", int'(if0.count_valid), 0);
        check("reset dut0 busy", int'(busy0), 0);
        check("reset dut0 overrun", int'(ovr0), 0);
        check("reset dut1 valid", int'(if1.count_valid), 0);
        check("reset dut1 busy", int'(busy1), 0);
        rst = 1'b0;

        // All ones, all zeros, scattered bits.
        q0.push_back(16); frame0(16'hFFFF, "ones");  accept0("ones");
        q0.push_back(0);  frame0(16'h0000, "zeros"); accept0("zeros");
        q0.push_back(8);  frame0(16'hA5A5, "a5a5");  accept0("a5a5");

        // UNG-shaped streams: value b yields b+1 ones.
        q0.push_back(6);  frame0(16'h003F, "ung b5");  accept0("ung b5");
        q0.push_back(1);  frame0(16'h0001, "ung b0");  accept0("ung b0");
        q0.push_back(16); frame0(16'hFFFF, "ung b15"); accept0("ung b15");

        // Backpressure: result held, start ignored, then a single transfer.
        q0.push_back(8);
        frame0(16'h0F0F, "hold");
        for (int k = 0; k < 40; k++) begin
            start0 = (k % 7 == 3);
            @(posedge clk); #1;
            check("hold count_out", int'(if0.count_out), 8);
            check("hold valid", int'(if0.count_valid), 1);
            check("hold busy", int'(busy0), 0);
        end
        start0 = 1'b0;
        accept0("hold");
        repeat (3) @(posedge clk);
        #1 check("no queued start", int'(busy0), 0);

        // Reset in the middle of a frame.
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            un0 = 1'b1;
            @(posedge clk); #1;
        end
        pulse_rst();
        un0 = 1'b0;
        check("midrst busy", int'(busy0), 0);
        check("midrst valid", int'(if0.count_valid), 0);
        check("midrst count_out", int'(if0.count_out), 0);
        check("midrst overrun", int'(ovr0), 0);
        q0.push_back(12); frame0(16'h0FFF, "after rst"); accept0("after rst");

        // Continuous, nobody accepting: overwrite and sticky overrun.
        pulse_rst();
        start1_pulse();
        feed1(16'h0007, 1'b0);
        check("cont1 count", int'(if1.count_out), 3);
        check("cont1 valid", int'(if1.count_valid), 1);
        check("cont1 overrun", int'(ovr1), 0);
        check("cont1 busy", int'(busy1), 1);
        feed1(16'h007F, 1'b0);
        check("cont2 count", int'(if1.count_out), 7);
        check("cont2 overrun", int'(ovr1), 1);
        feed1(16'h01FF, 1'b0);
        check("cont3 count", int'(if1.count_out), 9);
        check("cont3 overrun", int'(ovr1), 1);
        q1.push_back(9);
        feed1(16'h0000, 1'b1);
        check("cont4 overrun sticky", int'(ovr1), 1);
        check("cont4 valid", int'(if1.count_valid), 1);
        pulse_rst();
        check("cont rst overrun", int'(ovr1), 0);
        check("cont rst valid", int'(if1.count_valid), 0);
        check("cont rst busy", int'(busy1), 0);

        // Continuous, accept coinciding with each new result: no overrun.
        q1.push_back(3); q1.push_back(7); q1.push_back(9);
        start1_pulse();
        feed1(16'h0007, 1'b1);
        check("sim1 count", int'(if1.count_out), 3);
        check("sim1 overrun", int'(ovr1), 0);
        feed1(16'h007F, 1'b1);
        check("sim2 count", int'(if1.count_out), 7);
        check("sim2 valid", int'(if1.count_valid), 1);
        check("sim2 overrun", int'(ovr1), 0);
        feed1(16'h01FF, 1'b1);
        check("sim3 count", int'(if1.count_out), 9);
        check("sim3 overrun", int'(ovr1), 0);
        feed1(16'h0000, 1'b1);
        check("sim4 count", int'(if1.count_out), 0);
        check("sim4 overrun", int'(ovr1), 0);
        pulse_rst();

        repeat (2) @(posedge clk);
        #1;
        check("dut0 pending expectations", q0.size(), 0);
        check("dut1 pending expectations", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
